ahb_master_port: RTL and testbench

Initiator-side bus interface that turns a single command from a local engine into one arbitrated AHB-style transaction. It raises `hreq` toward the slave-side arbiter, waits for `hgrant`, and then drives a pipelined burst of address and data phases. It holds `hreq` until the final address phase so that the arbiter's beat monitor releases the grant on the last beat. One instance sits between each bus master core and the interconnect, and imports `AHB_package` for `hburst_type`.

---
 rtl/ahb_master_port.sv | 204 ++++++++++++++++++++
 tb/tb_ahb_master_port.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_port.sv
// ahb_master_port: turns one engine command into one arbitrated AHB burst (request, grant, pipelined address/data phases).
// Latency: hreq one cycle after accept, NONSEQ one cycle after grant, done one cycle after the last data phase (SINGLE: 4 cycles min).
// Backpressure: hwait stalls address+data phases; cmd_ready only in IDLE; AHB_MASTER_BUSY_EN inserts BUSY when wr_valid is low.

package AHB_package;
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_type;
endpackage

module ahb_master_port
  import AHB_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hreset,
  // command from the local engine
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  hburst_type            cmd_burst,
  input  logic [2:0]            cmd_size,
  // arbitration
  output logic                  hreq,
  input  logic                  hgrant,
  input  logic                  hwait,
  // address phase
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output hburst_type            hburst,
  output logic [2:0]            hsize,
  // bus data
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  // engine data streams
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  done
);

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_BUSY   = 2'd1;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

`ifdef AHB_MASTER_BUSY_EN
  localparam bit BusyEn = 1'b1;
`else
  localparam bit BusyEn = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_REQUEST, ST_BURST, ST_LAST} state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  hreq_q;
  logic [1:0]            htrans_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic                  hwrite_q;
  hburst_type            hburst_q;
  logic [2:0]            hsize_q;
  logic [3:0]            cnt_q;      // beats still to be issued after the current one
  logic                  dphase_q;   // a data phase is in progress this cycle
  logic                  done_q;

  function automatic logic [3:0] beats_m1(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4'd3;
      WRAP8, INCR8:   return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

  function automatic logic is_wrap(input hburst_type b);
    return (b == WRAP4) || (b == WRAP8) || (b == WRAP16);
  endfunction

  logic [ADDR_WIDTH-1:0] step_d;
  logic [ADDR_WIDTH-1:0] blk_mask_d;
  logic [ADDR_WIDTH-1:0] seq_addr_d;
  logic [ADDR_WIDTH-1:0] next_addr_d;

  // Next beat address: linear step, or wrap inside the aligned beats*size block
  always_comb begin
    step_d      = ADDR_WIDTH'(1) << hsize_q;
    blk_mask_d  = ((ADDR_WIDTH'(beats_m1(hburst_q)) + ADDR_WIDTH'(1)) << hsize_q) - ADDR_WIDTH'(1);
    seq_addr_d  = haddr_q + step_d;
    next_addr_d = seq_addr_d;
    if (is_wrap(hburst_q)) begin
      next_addr_d = (haddr_q & ~blk_mask_d) | (seq_addr_d & blk_mask_d);
    end
  end

  logic addr_active;
  logic hold_busy;

  assign addr_active = (htrans_q == HT_NONSEQ) || (htrans_q == HT_SEQ);
  // write data not ready at an advance point: park the bus in BUSY instead of issuing SEQ
  assign hold_busy   = BusyEn && hwrite_q && !wr_valid;

  // Control FSM: request, burst issue, final data phase; all address-phase outputs registered here
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      hreq_q      <= 1'b0;
      htrans_q    <= HT_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hburst_q    <= SINGLE;
      hsize_q     <= 3'd0;
      cnt_q       <= 4'd0;
      dphase_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // an accepted NONSEQ/SEQ opens the data phase of the following cycle(s)
      if (!hwait) begin
        dphase_q <= addr_active;
      end
      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            hreq_q      <= 1'b1;
            haddr_q     <= cmd_addr;
            hwrite_q    <= cmd_write;
            hburst_q    <= cmd_burst;
            hsize_q     <= cmd_size;
            cnt_q       <= beats_m1(cmd_burst);
            state_q     <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (hgrant) begin
            htrans_q <= HT_NONSEQ;
            // a single-beat burst drives its last address phase right away
            hreq_q   <= (cnt_q != 4'd0);
            state_q  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!hwait) begin
            if (addr_active && (cnt_q == 4'd0)) begin
              htrans_q <= HT_IDLE;
              hreq_q   <= 1'b0;
              state_q  <= ST_LAST;
            end else if (hold_busy) begin
              htrans_q <= HT_BUSY;
            end else begin
              htrans_q <= HT_SEQ;
              haddr_q  <= next_addr_d;
              cnt_q    <= cnt_q - 4'd1;
              // drop the request in the cycle the final address phase appears
              hreq_q   <= (cnt_q != 4'd1);
            end
          end
        end
        ST_LAST: begin
          if (!hwait) begin
            done_q      <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign hreq      = hreq_q;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hburst    = hburst_q;
  assign hsize     = hsize_q;
  assign done      = done_q;

  // Data phase: completes in any data-phase cycle without a slave wait
  assign wr_ready = dphase_q && hwrite_q && !hwait;
  assign rd_valid = dphase_q && !hwrite_q && !hwait;
  assign hwdata   = (dphase_q && hwrite_q) ? wr_data : '0;
  assign rd_data  = rd_valid ? hrdata : '0;

endmodule

// File: tb/tb_ahb_master_port.sv
// tb_ahb_master_port: directed table plus randomized bursts against a transaction-level address/data model.
// Latency: none (bench).
// Backpressure: drives random hwait, delayed grants and stray cmd_valid.
module tb_ahb_master_port;
  import AHB_package::*;

`ifdef AHB_MASTER_BUSY_EN
  localparam bit BusyBuild = 1'b1;
`else
  localparam bit BusyBuild = 1'b0;
`endif

  logic        hclk, hreset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  hburst_type  cmd_burst, hburst;
  logic [2:0]  cmd_size, hsize;
  logic        hreq, hgrant, hwait, hwrite;
  logic [31:0] haddr, hwdata, hrdata, wr_data, rd_data;
  logic [1:0]  htrans;
  logic        wr_valid, wr_ready, rd_valid, done;

  ahb_master_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
    .hreq(hreq), .hgrant(hgrant), .hwait(hwait),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hburst(hburst), .hsize(hsize),
    .hwdata(hwdata), .hrdata(hrdata),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: beat count and beat addresses straight from the burst rules
  function automatic int nbeats(input hburst_type b);
    case (b)
      WRAP4, INCR4:   return 4;
      WRAP8, INCR8:   return 8;
      WRAP16, INCR16: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input hburst_type b,
                                           input logic [2:0] s, input int i);
    logic [31:0] bytes, blk, base;
    bytes = 32'd1 << s;
    blk   = bytes * 32'(nbeats(b));
    if (b == WRAP4 || b == WRAP8 || b == WRAP16) begin
      base = a - (a % blk);
      return base + ((a - base + bytes * 32'(i)) % blk);
    end
    return a + bytes * 32'(i);
  endfunction

  task automatic issue_cmd(input logic [31:0] a, input bit w, input hburst_type b, input logic [2:0] s);
    int k;
    k = 0;
    @(posedge hclk); #2;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_burst = b; cmd_size = s;
    hgrant = 1'b0; hwait = 1'b0; wr_valid = 1'b1;
    #2;
    while (!cmd_ready && k < 20) begin
      @(posedge hclk); #4;
      k++;
    end
    chk("cmd_accept", cmd_ready, 1);
  endtask

  // One full transaction with random slave behaviour; every cycle is checked against the model
  task automatic run_txn(input logic [31:0] a, input bit w, input hburst_type b, input logic [2:0] s,
                         input int gdly, input int wpct, input int wait_at,
                         output int acc, output logic [31:0] last_a, output int lat);
    int beats, cyc, xfers, last_x, gcyc;
    bit pend, act, pstall, done_seen, xfer_exp;
    logic [31:0] paddr;
    logic [1:0]  ptrans;
    beats = nbeats(b); acc = 0; last_a = '0; lat = -1; xfers = 0; last_x = -1; gcyc = -1;
    pend = 0; pstall = 0; done_seen = 0; paddr = '0; ptrans = 2'd0;
    issue_cmd(a, w, b, s);
    cyc = 0;
    while (!done_seen && cyc < 300) begin
      @(posedge hclk);
      cyc++;
      #2;
      cmd_valid = (done || cmd_ready) ? 1'b0 : 1'($urandom_range(1));
      cmd_addr  = $urandom;
      hwait     = (cyc == wait_at) || ($urandom_range(99) < wpct);
      hgrant    = (cyc >= gdly + 1) && !hwait && (gcyc < 0 ? 1'b1 : 1'($urandom_range(1)));
      wr_valid  = BusyBuild ? 1'b1 : 1'($urandom_range(1));
      wr_data   = $urandom;
      hrdata    = $urandom;
      #2;
      act = (htrans == 2'd2) || (htrans == 2'd3);
      if (!done) chk("cmd_ready_busy", cmd_ready, 0);
      if (gcyc < 0) begin
        chk("req_hreq", hreq, 1);
        chk("req_htrans", htrans, 0);
        if (hgrant) gcyc = cyc;
      end else if (cyc == gcyc + 1) begin
        chk("nonseq_after_grant", htrans, 2);
      end
      if (pstall) begin
        chk("stall_addr", haddr, paddr);
        chk("stall_trans", htrans, ptrans);
      end
      if (act) begin
        if (acc < beats) chk("addr", haddr, exp_addr(a, b, s, acc));
        else chk("extra_beat", acc, beats - 1);
        chk("trans", htrans, (acc == 0) ? 2 : 3);
        chk("hreq_burst", hreq, (acc != beats - 1));
        chk("hwrite", hwrite, w);
        chk("hburst", hburst, b);
        chk("hsize", hsize, s);
      end else if (gcyc >= 0 && cyc > gcyc) begin
        chk("hreq_after_last", hreq, 0);
      end
      xfer_exp = pend && !hwait;
      chk("wr_ready", wr_ready, w && xfer_exp);
      chk("rd_valid", rd_valid, !w && xfer_exp);
      if (xfer_exp) begin
        xfers++;
        last_x = cyc;
        if (w) chk("hwdata", hwdata, wr_data);
        else   chk("rd_data", rd_data, hrdata);
      end
      if (done) begin
        done_seen = 1;
        lat = cyc;
        chk("done_timing", cyc, last_x + 1);
        chk("done_xfers", xfers, beats);
      end
      pstall = act && hwait;
      paddr  = haddr;
      ptrans = htrans;
      if (!hwait) begin
        pend = act;
        if (act) begin
          last_a = haddr;
          acc++;
        end
      end
    end
    if (!done_seen) chk("done_timeout", 0, 1);
    @(posedge hclk); #2;
    cmd_valid = 1'b0; hwait = 1'b0; hgrant = 1'b0;
    #2;
    chk("done_one_cycle", done, 0);
    chk("ready_after_done", cmd_ready, 1);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    hburst_type  burst;
    logic [2:0]  size;
    int          gdly;
    int          wait_at;
    int          exp_beats;
    logic [31:0] exp_last;
    int          exp_lat;
  } vec_t;

  vec_t vt [9];

`ifdef AHB_MASTER_BUSY_EN
  logic [1:0]  busy_tr [6] = '{2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3};
  logic [31:0] busy_ad [6] = '{32'h80, 32'h80, 32'h80, 32'h84, 32'h88, 32'h8C};
`endif

  initial begin
    int nb, lat, dcnt;
    logic [31:0] la, ra;
    hburst_type rb;
    logic [2:0] rs;

    vt[0] = '{32'h100,  1'b1, SINGLE, 3'd2, 0, 0, 1,  32'h100,   4};
    vt[1] = '{32'h200,  1'b0, INCR4,  3'd2, 0, 4, 4,  32'h20C,   8};
    vt[2] = '{32'h1C,   1'b1, WRAP8,  3'd2, 0, 0, 8,  32'h18,    11};
    vt[3] = '{32'h40,   1'b0, INCR4,  3'd2, 5, 0, 4,  32'h4C,    12};
    vt[4] = '{32'h34,   1'b1, WRAP4,  3'd1, 1, 0, 4,  32'h32,    8};
    vt[5] = '{32'h4B,   1'b0, WRAP16, 3'd0, 0, 0, 16, 32'h4A,    19};
    vt[6] = '{32'hFFF8, 1'b1, INCR8,  3'd1, 2, 0, 8,  32'h10006, 13};
    vt[7] = '{32'h7,    1'b0, INCR,   3'd0, 0, 0, 1,  32'h7,     4};
    vt[8] = '{32'h1000, 1'b1, INCR16, 3'd2, 0, 0, 16, 32'h103C,  19};

    hreset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_burst = SINGLE;
    cmd_size = 3'd0; hgrant = 1'b0; hwait = 1'b0; hrdata = '0; wr_data = 32'hDEADBEEF; wr_valid = 1'b1;
    repeat (3) @(posedge hclk);
    #4;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_hreq", hreq, 0);
    chk("rst_htrans", htrans, 0);
    chk("rst_outputs", |{haddr, hwrite, hburst, hsize, hwdata, rd_valid, rd_data, wr_ready, done}, 0);
    @(posedge hclk); #2;
    hreset = 1'b0;

    // directed table
    for (int i = 0; i < 9; i++) begin
      run_txn(vt[i].addr, vt[i].wr, vt[i].burst, vt[i].size, vt[i].gdly, 0, vt[i].wait_at, nb, la, lat);
      chk($sformatf("vec%0d_beats", i), nb, vt[i].exp_beats);
      chk($sformatf("vec%0d_last_addr", i), la, vt[i].exp_last);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
    end

    // reset during beat 3 of an INCR8 write
    issue_cmd(32'h300, 1'b1, INCR8, 3'd2);
    for (int c = 1; c <= 4; c++) begin
      @(posedge hclk); #2;
      cmd_valid = 1'b0; hgrant = 1'b1; hwait = 1'b0; wr_data = 32'hA5A5A5A5;
      #2;
    end
    chk("beat3_addr", haddr, 32'h308);
    chk("beat3_trans", htrans, 3);
    #1 hreset = 1'b1;
    #1;
    chk("midrst_cmd_ready", cmd_ready, 0);
    chk("midrst_hreq", hreq, 0);
    chk("midrst_htrans", htrans, 0);
    chk("midrst_outputs", |{haddr, hwrite, hburst, hsize, hwdata, rd_valid, rd_data, wr_ready, done}, 0);
    @(posedge hclk); #2;
    hreset = 1'b0; hgrant = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge hclk); #4;
      if (done) dcnt++;
    end
    chk("no_done_after_reset", dcnt, 0);
    run_txn(32'h40, 1'b0, SINGLE, 3'd2, 0, 0, 0, nb, la, lat);
    chk("post_reset_beats", nb, 1);
    chk("post_reset_addr", la, 32'h40);

`ifdef AHB_MASTER_BUSY_EN
    // INCR4 write with write data missing for two cycles after beat 1
    issue_cmd(32'h80, 1'b1, INCR4, 3'd2);
    for (int c = 1; c <= 9; c++) begin
      @(posedge hclk); #2;
      cmd_valid = 1'b0; hgrant = 1'b1; hwait = 1'b0; wr_data = $urandom;
      wr_valid = !(c == 2 || c == 3);
      #2;
      if (c >= 2 && c <= 7) begin
        chk($sformatf("busy_trans_c%0d", c), htrans, busy_tr[c-2]);
        chk($sformatf("busy_addr_c%0d", c), haddr, busy_ad[c-2]);
        chk($sformatf("busy_hreq_c%0d", c), hreq, (c < 7));
      end
      if (c == 9) chk("busy_done", done, 1);
    end
`endif

    // randomized bursts
    for (int i = 0; i < 25; i++) begin
      rb = hburst_type'($urandom_range(7));
      rs = 3'($urandom_range(2));
      ra = $urandom;
      ra = (ra >> rs) << rs;
      run_txn(ra, 1'($urandom_range(1)), rb, rs, $urandom_range(3), 30, 0, nb, la, lat);
      chk("rand_beats", nb, nbeats(rb));
      chk("rand_last_addr", la, exp_addr(ra, rb, rs, nbeats(rb) - 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
